// File: rtl/buffer_scheduler.sv
// Periodic drain scheduler for four priority buffers of 2-bit packets.
// Once per tick it scores buffer occupancy, picks latency or reliability
// mode and a target buffer, then pops one packet over a req/ack handshake
// and latches the payload for the display driver.
module buffer_scheduler #(
  parameter int unsigned TICK_DIV    = 150000000,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned DEPTH       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] occ,
  input  logic        pop_ack,
  input  logic [1:0]  pop_data,
  output logic        pop_req,
  output logic [1:0]  pop_sel,
  output logic        mode,
  output logic [1:0]  disp,
  output logic        disp_valid,
  output logic [7:0]  tx_cnt,
  output logic        err,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned WW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [WW-1:0]   wait_cnt;

  logic [3:0][2:0] lvl;
  logic [5:0]      rs;
  logic [5:0]      ls;
  logic            mode_next;
  logic            any_nz;
  logic [1:0]      lat_pri;
  logic [1:0]      rel_pri;
  logic [1:0]      pri;
  logic [1:0]      sel_next;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));
  assign busy = (state != S_IDLE);

  // Free-running tick divider, independent of the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Clamp each occupancy field to the physical buffer depth
  always_comb begin
    lvl = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (occ[3*k +: 3] > 3'(DEPTH)) begin
        lvl[k] = 3'(DEPTH);
      end else begin
        lvl[k] = occ[3*k +: 3];
      end
    end
  end

  // Weighted scores; ties resolve to reliability mode
  always_comb begin
    rs = 6'(lvl[0]) + 6'd2 * 6'(lvl[1]) + 6'd3 * 6'(lvl[2]) + 6'd4 * 6'(lvl[3]);
    ls = 6'd4 * 6'(lvl[0]) + 6'd3 * 6'(lvl[1]) + 6'd2 * 6'(lvl[2]) + 6'(lvl[3]);
    mode_next = (rs >= ls);
    any_nz = (lvl != '0);
  end

  // Primary pick per mode, then fall back to the first non-empty buffer
  // in that mode's priority order if the primary one is empty
  always_comb begin
    if (lvl[0] > lvl[1] && lvl[0] > lvl[2] && lvl[0] > lvl[3]) begin
      lat_pri = 2'd0;
    end else if (lvl[1] > lvl[0] && lvl[1] > lvl[2] && lvl[1] > lvl[3]) begin
      lat_pri = 2'd1;
    end else if (lvl[2] > lvl[3]) begin
      lat_pri = 2'd2;
    end else begin
      lat_pri = 2'd3;
    end

    if (lvl[3] > lvl[0] && lvl[3] > lvl[1] && lvl[3] > lvl[2]) begin
      rel_pri = 2'd3;
    end else if (lvl[2] > lvl[0] && lvl[2] > lvl[1] && lvl[2] > lvl[3]) begin
      rel_pri = 2'd2;
    end else if (lvl[1] > lvl[0]) begin
      rel_pri = 2'd1;
    end else begin
      rel_pri = 2'd0;
    end

    pri = mode_next ? rel_pri : lat_pri;
    sel_next = pri;
    if (lvl[pri] == 3'd0) begin
      if (mode_next) begin
        if (lvl[3] != 3'd0)      sel_next = 2'd3;
        else if (lvl[2] != 3'd0) sel_next = 2'd2;
        else if (lvl[1] != 3'd0) sel_next = 2'd1;
        else if (lvl[0] != 3'd0) sel_next = 2'd0;
      end else begin
        if (lvl[0] != 3'd0)      sel_next = 2'd0;
        else if (lvl[1] != 3'd0) sel_next = 2'd1;
        else if (lvl[2] != 3'd0) sel_next = 2'd2;
        else if (lvl[3] != 3'd0) sel_next = 2'd3;
      end
    end
  end

  // Scheduler FSM: IDLE -> EVAL -> REQ -> IDLE, with ack timeout abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pop_req    <= 1'b0;
      pop_sel    <= '0;
      mode       <= 1'b0;
      disp       <= '0;
      disp_valid <= 1'b0;
      tx_cnt     <= '0;
      err        <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      disp_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick && any_nz) begin
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          mode     <= mode_next;
          pop_sel  <= sel_next;
          pop_req  <= 1'b1;
          wait_cnt <= '0;
          state    <= S_REQ;
        end
        S_REQ: begin
          if (pop_ack) begin
            disp       <= pop_data;
            disp_valid <= 1'b1;
            tx_cnt     <= tx_cnt + 8'd1;
            pop_req    <= 1'b0;
            state      <= S_IDLE;
          end else if (wait_cnt == WW'(ACK_TIMEOUT - 1)) begin
            err     <= 1'b1;
            pop_req <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          pop_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_scheduler.sv
// Directed testbench for buffer_scheduler with a short tick period.
module tb_buffer_scheduler;

  localparam int unsigned TD = 8;
  localparam int unsigned AT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] occ;
  logic        pop_ack;
  logic [1:0]  pop_data;
  logic        pop_req;
  logic [1:0]  pop_sel;
  logic        mode;
  logic [1:0]  disp;
  logic        disp_valid;
  logic [7:0]  tx_cnt;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [2:0] tcnt;
  logic [7:0] exp_tx;
  logic [1:0] exp_disp;
  logic       seen;

  buffer_scheduler #(.TICK_DIV(TD), .ACK_TIMEOUT(AT), .DEPTH(6)) dut (
    .clk(clk), .rst(rst), .occ(occ), .pop_ack(pop_ack), .pop_data(pop_data),
    .pop_req(pop_req), .pop_sel(pop_sel), .mode(mode), .disp(disp),
    .disp_valid(disp_valid), .tx_cnt(tx_cnt), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference tick phase: tcnt == TD-1 marks the tick cycle
  always @(posedge clk) begin
    if (rst) tcnt <= '0;
    else if (tcnt == 3'(TD - 1)) tcnt <= '0;
    else tcnt <= tcnt + 3'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (tcnt != 3'(TD - 1) && n < 2 * TD) begin
      step();
      n++;
    end
  endtask

  // One scheduled pop: ack arrives in the dly-th cycle of pop_req
  task automatic run_pop(input logic [11:0] o, input logic [1:0] esel, input logic emode,
                         input int dly, input logic [1:0] data, input string tag);
    occ = o;
    wait_tick();
    step();
    check({tag, "_eval_busy"}, busy, 1);
    check({tag, "_eval_req"}, pop_req, 0);
    step();
    check({tag, "_req"}, pop_req, 1);
    check({tag, "_sel"}, pop_sel, esel);
    check({tag, "_mode"}, mode, emode);
    occ = 12'o0006;
    for (int i = 1; i < dly; i++) begin
      step();
      check({tag, "_req_hold"}, pop_req, 1);
      check({tag, "_sel_hold"}, pop_sel, esel);
    end
    pop_ack = 1'b1;
    pop_data = data;
    occ = 12'o0000;
    step();
    pop_ack = 1'b0;
    exp_tx = exp_tx + 8'd1;
    exp_disp = data;
    check({tag, "_disp"}, disp, exp_disp);
    check({tag, "_dvalid"}, disp_valid, 1);
    check({tag, "_tx"}, tx_cnt, exp_tx);
    check({tag, "_req_drop"}, pop_req, 0);
    check({tag, "_idle"}, busy, 0);
    step();
    check({tag, "_dvalid_pulse"}, disp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; occ = '0; pop_ack = 1'b0; pop_data = '0;
    exp_tx = '0; exp_disp = '0;
    step(); step(); step();
    rst = 1'b0;

    // Reset state and quiet idle with empty buffers
    check("rst_req", pop_req, 0);
    check("rst_sel", pop_sel, 0);
    check("rst_mode", mode, 0);
    check("rst_disp", disp, 0);
    check("rst_dvalid", disp_valid, 0);
    check("rst_tx", tx_cnt, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      step();
      if (busy || pop_req) seen = 1'b1;
    end
    check("idle_quiet", seen, 0);

    // Latency pick L=(3,1,0,0)
    run_pop(12'o0013, 2'd0, 1'b0, 1, 2'b10, "lat");
    // pop_ack while idle must be ignored
    pop_ack = 1'b1; pop_data = 2'b11;
    step();
    pop_ack = 1'b0;
    check("stray_ack_tx", tx_cnt, exp_tx);
    check("stray_ack_disp", disp, exp_disp);
    check("stray_ack_dvalid", disp_valid, 0);

    // Reliability pick L=(0,1,2,5), ack in 4th request cycle
    run_pop(12'o5210, 2'd3, 1'b1, 4, 2'b01, "rel");
    // Fallback: latency primary B4 empty -> B1
    run_pop(12'o0022, 2'd0, 1'b0, 2, 2'b11, "fb_lat");
    // Score tie -> reliability, else-B1 rule
    run_pop(12'o6666, 2'd0, 1'b1, 1, 2'b00, "tie");

    // Ack timeout
    occ = 12'o0013;
    wait_tick();
    step();
    step();
    check("to_req", pop_req, 1);
    occ = 12'o0000;
    seen = 1'b0;
    for (int k = 1; k < AT; k++) begin
      step();
      if (err || !pop_req) seen = 1'b1;
    end
    check("to_early", seen, 0);
    step();
    check("to_err", err, 1);
    check("to_req_drop", pop_req, 0);
    check("to_idle", busy, 0);
    check("to_disp", disp, exp_disp);
    check("to_tx", tx_cnt, exp_tx);
    step();
    check("to_err_pulse", err, 0);
    run_pop(12'o0013, 2'd0, 1'b0, 2, 2'b01, "retry");

    // Field value 7 clamps to 6: L=(0,0,6,6) -> rel, fallback to B4
    run_pop(12'o6700, 2'd3, 1'b1, 1, 2'b10, "clamp");

    // Reset during REQ
    occ = 12'o0013;
    wait_tick();
    step();
    step();
    check("mid_req", pop_req, 1);
    occ = 12'o0000;
    rst = 1'b1;
    pop_ack = 1'b1; pop_data = 2'b11;
    step();
    rst = 1'b0;
    pop_ack = 1'b0;
    exp_tx = '0; exp_disp = '0;
    check("mid_rst_req", pop_req, 0);
    check("mid_rst_tx", tx_cnt, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_dvalid", disp_valid, 0);
    check("mid_rst_disp", disp, 0);
    check("mid_rst_busy", busy, 0);

    // tx_cnt wrap 255 -> 0
    for (int i = 0; i < 255; i++) begin
      run_pop(12'o0013, 2'd0, 1'b0, 1, 2'(i), "pre");
    end
    check("tx_255", tx_cnt, 8'd255);
    run_pop(12'o0013, 2'd0, 1'b0, 1, 2'b11, "wrap");
    check("tx_wrap", tx_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buffer_scheduler.md
Name: buffer_scheduler

Overview:
Periodic drain scheduler for the four 6-entry priority buffers (B1..B4) of 2-bit packets. Once per scheduling tick it samples buffer occupancies, computes reliability/latency scores, picks the operating mode and target buffer, and pops one packet over a req/ack handshake. The popped payload is latched to the display output. It sits between the buffer storage/input block and the display driver, and replaces ad-hoc dequeue logic.

Parameters:
TICK_DIV, 150000000, clk cycles per scheduling tick (3 s at 50 MHz); must be ≥ 4.
ACK_TIMEOUT, 15, max cycles in REQ waiting for pop_ack before abort.
DEPTH, 6, entries per buffer; occupancy inputs are clamped to this value.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
occ  in  12  occupancy; occ[3k+2:3k] = count of valid entries in buffer k+1
pop_ack  in  1  buffer storage accepted pop; pop_data valid this cycle
pop_data  in  2  payload of popped head entry
pop_req  out  1  pop request, held until ack or timeout
pop_sel  out  2  target buffer index, 0 = B1 .. 3 = B4; stable while pop_req = 1
mode  out  1  1 = reliability, 0 = latency; updated in EVAL
disp  out  2  last transmitted payload
disp_valid  out  1  one-cycle pulse when disp updates
tx_cnt  out  8  packets transmitted, wraps 255 -> 0
err  out  1  one-cycle pulse on ack timeout
busy  out  1  1 when state != IDLE

Behaviour:
- Reset: one clock, synchronous, active-high. Reset drives state IDLE and the tick counter to 0. All outputs go to 0, including mode, disp and tx_cnt. Reset takes priority over every other event. A reset during REQ drops pop_req on that edge, with no capture and no err.
- Tick counter: counts 0..TICK_DIV-1. tick is an internal 1-cycle pulse on the cycle the counter equals TICK_DIV-1; the counter then wraps to 0. The counter free-runs regardless of FSM state.
- L1..L4: occ fields, each clamped to DEPTH (7 -> 6).
- Scores, unsigned 6-bit (max 60):
  - RS = L1 + 2·L2 + 3·L3 + 4·L4
  - LS = 4·L1 + 3·L2 + 2·L3 + L4
  - mode = (RS >= LS); ties give reliability.
- Primary select, latency mode (mode 0):
  - B1 if L1 is strictly greater than all others;
  - else B2 if L2 is strictly greatest;
  - else B3 if L3 > L4;
  - else B4.
- Primary select, reliability mode (mode 1):
  - B4 if L4 is strictly greatest;
  - else B3 if L3 is strictly greatest;
  - else B2 if L2 > L1;
  - else B1.
- Empty fallback: if the primary buffer has L = 0, select the first non-empty buffer in mode order. Latency order is B1, B2, B3, B4. Reliability order is B4, B3, B2, B1.
- FSM, IDLE:
  - On tick with all L = 0: stay IDLE.
  - On tick with any L > 0: go to EVAL.
  - Ticks arriving outside IDLE are ignored and not queued.
- FSM, EVAL (1 cycle): register mode and pop_sel from the current occ, then go to REQ.
- FSM, REQ: pop_req = 1, a wait counter starts at 0.
  - pop_ack = 1: on that edge latch disp <= pop_data, pulse disp_valid, increment tx_cnt, drop pop_req, go to IDLE. Latency from tick to pop_req is 2 cycles.
  - No ack after ACK_TIMEOUT cycles in REQ: pulse err, drop pop_req, go to IDLE; disp and tx_cnt unchanged.
  - pop_ack outside REQ is ignored.
- Occ changes after EVAL do not alter pop_sel for the current request.

Test Plan:
1. Reset and idle, with TICK_DIV = 8: assert rst for 3 cycles with occ = 0 -> all outputs 0; after ticks busy stays 0 and pop_req is never asserted.
2. Latency pick: occ L = (3,1,0,0) gives RS = 5, LS = 15, so mode 0. On tick: pop_req = 1 two cycles later with pop_sel = 0. Ack with pop_data = 2'b10 -> disp = 2'b10, one-cycle disp_valid, tx_cnt = 1.
3. Reliability pick: L = (0,1,2,5) gives RS = 28, LS = 12, so mode 1 -> pop_sel = 3. Ack after 4 cycles -> pop_req held steady for all 4 cycles with pop_sel constant.
4. Fallback: L = (2,2,0,0), latency mode; the primary pick is B4, which is empty -> pop_sel = 0. Separately, L = (6,6,6,6) gives RS = LS = 60, so mode 1, and pop_sel = 0 via the "else B1" rule.
5. Timeout: hold pop_ack = 0 -> err pulses exactly ACK_TIMEOUT cycles after pop_req rises; disp and tx_cnt unchanged, back in IDLE. The next tick retries normally.
6. Edge cases:
   - occ field = 7 is treated as 6.
   - rst asserted mid-REQ -> pop_req = 0 next edge, tx_cnt = 0.
   - Preload tx_cnt to 255 via 255 acks; one more ack -> tx_cnt wraps to 0.
